// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcodes,
// control-field encodings and the control word produced for each state.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // pc_write and branch are internal; they combine with zero into PCEn at the top
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle. The controller is the master: it
// receives Opcode/zero and drives every select, enable and status output.
interface multicycle_controller_if;
    logic [5:0] Opcode;
    logic       zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  Opcode, zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCEn, instr_done, illegal_op, state
    );

    modport slave (
        output Opcode, zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCEn, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mc_control_rom.sv
// Combinational control store: maps the current state to its control word.
// Unreachable codes fall to the all-zero word.
module mc_control_rom
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared-memory multicycle MIPS datapath: state
// register, next-state decode, PCEn, reset gating of outputs and sticky illegal_op.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    Reset,
    multicycle_controller_if.master bus
);

    state_t state_q, state_d;
    logic   illegal_op_q, illegal_op_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_g;

    mc_control_rom u_rom (
        .state (state_q),
        .ctrl  (ctrl)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_FETCH;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        illegal_op_d = illegal_op_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            // The IR holds the opcode, so it is still valid one state after DECODE
            S_MEMADR:  state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset masks the FETCH word so no enable reaches the datapath while held
    assign ctrl_g = Reset ? ctrl_t'('0) : ctrl;

    assign bus.IorD       = ctrl_g.iord;
    assign bus.MemWrite   = ctrl_g.mem_write;
    assign bus.IRWrite    = ctrl_g.ir_write;
    assign bus.RegDst     = ctrl_g.reg_dst;
    assign bus.MemtoReg   = ctrl_g.mem_to_reg;
    assign bus.RegWrite   = ctrl_g.reg_write;
    assign bus.ALUSrcA    = ctrl_g.alu_src_a;
    assign bus.ALUSrcB    = ctrl_g.alu_src_b;
    assign bus.ALUOp      = ctrl_g.alu_op;
    assign bus.PCSrc      = ctrl_g.pc_src;
    assign bus.PCEn       = ctrl_g.pc_write | (ctrl_g.branch & bus.zero);
    assign bus.instr_done = ctrl_g.instr_done;
    assign bus.illegal_op = illegal_op_q & ~Reset;
    assign bus.state      = state_q;

endmodule
